// File: rtl/alu_writeback.sv
// Writeback stage behind the 16-bit ALU: commits masked S/Z/C/V flags, buffers register-file
// results in a 2-entry in-order FIFO, feeds carry back to the ALU and counts retired operations.
module alu_writeback #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_result_i,
  input  logic [3:0]           in_flags_i,
  input  logic [3:0]           in_flag_mask_i,
  input  logic                 in_we_i,
  input  logic [ADDR_BITS-1:0] in_rd_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [WIDTH-1:0]     wb_data_o,
  output logic [ADDR_BITS-1:0] wb_addr_o,
  input  logic                 flag_load_i,
  input  logic [3:0]           flag_load_val_i,
  output logic [3:0]           flags_o,
  output logic                 carry_out_o,
  output logic [CNT_BITS-1:0]  ops_retired_o
);

  localparam int EntryW = WIDTH + ADDR_BITS;

  logic [1:0]          count_q, count_d;
  logic [EntryW-1:0]   slot0_q, slot0_d;
  logic [EntryW-1:0]   slot1_q, slot1_d;
  logic [3:0]          flags_q, flags_d;
  logic [CNT_BITS-1:0] ops_q, ops_d;

  logic acc;
  logic push;
  logic pop;

  assign in_ready_o = (count_q != 2'd2) & ~rst_i;
  assign acc        = in_valid_i & in_ready_o;
  assign push       = acc & in_we_i;
  assign pop        = wb_valid_o & wb_ready_i;

  // Slot 0 is always the head; emptied slots are zeroed so the head reads 0 when the FIFO is empty.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (pop) begin
      slot0_d = slot1_q;
      slot1_d = '0;
    end
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        slot0_d = {in_rd_i, in_result_i};
      end else begin
        slot1_d = {in_rd_i, in_result_i};
      end
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // A direct flag load overrides the masked update coming from an accepted op.
  always_comb begin
    flags_d = flags_q;
    if (acc) begin
      flags_d = (flags_q & ~in_flag_mask_i) | (in_flags_i & in_flag_mask_i);
    end
    if (flag_load_i) begin
      flags_d = flag_load_val_i;
    end
  end

  always_comb begin
    ops_d = ops_q;
    if (acc && (ops_q != '1)) begin
      ops_d = ops_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
      flags_q <= 4'b0;
      ops_q   <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      flags_q <= flags_d;
      ops_q   <= ops_d;
    end
  end

  assign wb_valid_o    = (count_q != 2'd0);
  assign wb_data_o     = slot0_q[WIDTH-1:0];
  assign wb_addr_o     = slot0_q[EntryW-1:WIDTH];
  assign flags_o       = flags_q;
  assign carry_out_o   = flags_q[1];
  assign ops_retired_o = ops_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: a per-cycle vector table plus hand-written
// sequences for counter saturation and enqueue-to-writeback latency.
module tb_alu_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        inValid;
  logic        inReady;
  logic [15:0] inResult;
  logic [3:0]  inFlags;
  logic [3:0]  inMask;
  logic        inWe;
  logic [2:0]  inRd;
  logic        wbValid;
  logic        wbReady;
  logic [15:0] wbData;
  logic [2:0]  wbAddr;
  logic        flagLoad;
  logic [3:0]  flagLoadVal;
  logic [3:0]  flags;
  logic        carryOut;
  logic [15:0] opsRetired;

  logic        satReady;
  logic        satWbValid;
  logic [15:0] satWbData;
  logic [2:0]  satWbAddr;
  logic [3:0]  satFlags;
  logic        satCarry;
  logic [2:0]  satOps;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  alu_writeback dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(inValid), .in_ready_o(inReady), .in_result_i(inResult),
    .in_flags_i(inFlags), .in_flag_mask_i(inMask), .in_we_i(inWe), .in_rd_i(inRd),
    .wb_valid_o(wbValid), .wb_ready_i(wbReady), .wb_data_o(wbData), .wb_addr_o(wbAddr),
    .flag_load_i(flagLoad), .flag_load_val_i(flagLoadVal),
    .flags_o(flags), .carry_out_o(carryOut), .ops_retired_o(opsRetired)
  );

  // Narrow counter copy so saturation is reachable in a few cycles.
  alu_writeback #(.WIDTH(16), .ADDR_BITS(3), .CNT_BITS(3)) satDut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(inValid), .in_ready_o(satReady), .in_result_i(inResult),
    .in_flags_i(inFlags), .in_flag_mask_i(inMask), .in_we_i(inWe), .in_rd_i(inRd),
    .wb_valid_o(satWbValid), .wb_ready_i(wbReady), .wb_data_o(satWbData), .wb_addr_o(satWbAddr),
    .flag_load_i(flagLoad), .flag_load_val_i(flagLoadVal),
    .flags_o(satFlags), .carry_out_o(satCarry), .ops_retired_o(satOps)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] result;
    logic [3:0]  flg;
    logic [3:0]  mask;
    logic        we;
    logic [2:0]  rd;
    logic        wbRdy;
    logic        fload;
    logic [3:0]  floadVal;
    logic        expReady;
    logic        expWbValid;
    logic [15:0] expData;
    logic [2:0]  expAddr;
    logic [3:0]  expFlags;
    logic [15:0] expOps;
  } vec_t;

  localparam int NumVecs = 18;
  vec_t vecs [NumVecs];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_i       = v.rst;
    inValid     = v.valid;
    inResult    = v.result;
    inFlags     = v.flg;
    inMask      = v.mask;
    inWe        = v.we;
    inRd        = v.rd;
    wbReady     = v.wbRdy;
    flagLoad    = v.fload;
    flagLoadVal = v.floadVal;
  endtask

  task automatic idleInputs();
    applyStimulus('{0, 0, 16'h0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 4'h0,
                    0, 0, 16'h0, 3'd0, 4'h0, 16'h0});
  endtask

  initial begin
    int lat;

    //            rst vld result    flg    mask  we rd  wbR fl flv   | rdy wbv data     addr flags  ops
    vecs[0]  = '{1, 1, 16'h0055, 4'hF, 4'hF, 1, 3'd1, 0, 0, 4'h0,  0, 0, 16'h0000, 3'd0, 4'h0, 16'd0};
    vecs[1]  = '{1, 1, 16'h0055, 4'hF, 4'hF, 1, 3'd1, 0, 0, 4'h0,  0, 0, 16'h0000, 3'd0, 4'h0, 16'd0};
    vecs[2]  = '{0, 1, 16'd15,   4'h0, 4'hF, 1, 3'd3, 1, 0, 4'h0,  1, 1, 16'd15,   3'd3, 4'h0, 16'd1};
    vecs[3]  = '{0, 0, 16'h0000, 4'h0, 4'h0, 0, 3'd0, 1, 0, 4'h0,  1, 0, 16'h0000, 3'd0, 4'h0, 16'd1};
    vecs[4]  = '{0, 1, 16'd1,    4'h0, 4'h0, 1, 3'd1, 0, 0, 4'h0,  1, 1, 16'd1,    3'd1, 4'h0, 16'd2};
    vecs[5]  = '{0, 1, 16'd2,    4'h0, 4'h0, 1, 3'd2, 0, 0, 4'h0,  1, 1, 16'd1,    3'd1, 4'h0, 16'd3};
    vecs[6]  = '{0, 1, 16'd3,    4'h0, 4'h0, 1, 3'd3, 0, 0, 4'h0,  0, 1, 16'd1,    3'd1, 4'h0, 16'd3};
    vecs[7]  = '{0, 1, 16'd3,    4'h0, 4'h0, 1, 3'd3, 1, 0, 4'h0,  0, 1, 16'd2,    3'd2, 4'h0, 16'd3};
    vecs[8]  = '{0, 1, 16'd3,    4'h0, 4'h0, 1, 3'd3, 1, 0, 4'h0,  1, 1, 16'd3,    3'd3, 4'h0, 16'd4};
    vecs[9]  = '{0, 0, 16'h0000, 4'h0, 4'h0, 0, 3'd0, 1, 0, 4'h0,  1, 0, 16'h0000, 3'd0, 4'h0, 16'd4};
    vecs[10] = '{0, 1, 16'h7777, 4'hF, 4'h2, 0, 3'd4, 1, 0, 4'h0,  1, 0, 16'h0000, 3'd0, 4'h2, 16'd5};
    vecs[11] = '{0, 0, 16'h0000, 4'h0, 4'h0, 0, 3'd0, 1, 0, 4'h0,  1, 0, 16'h0000, 3'd0, 4'h2, 16'd5};
    vecs[12] = '{0, 1, 16'h1111, 4'hF, 4'hF, 0, 3'd0, 1, 1, 4'h4,  1, 0, 16'h0000, 3'd0, 4'h4, 16'd6};
    vecs[13] = '{0, 0, 16'h0000, 4'h0, 4'h0, 0, 3'd0, 1, 1, 4'h9,  1, 0, 16'h0000, 3'd0, 4'h9, 16'd6};
    vecs[14] = '{0, 1, 16'hBEEF, 4'h0, 4'h8, 1, 3'd7, 0, 0, 4'h0,  1, 1, 16'hBEEF, 3'd7, 4'h1, 16'd7};
    vecs[15] = '{0, 1, 16'h1234, 4'h2, 4'h2, 1, 3'd5, 0, 0, 4'h0,  1, 1, 16'hBEEF, 3'd7, 4'h3, 16'd8};
    vecs[16] = '{1, 1, 16'h4321, 4'hF, 4'hF, 1, 3'd2, 1, 0, 4'h0,  0, 0, 16'h0000, 3'd0, 4'h0, 16'd0};
    vecs[17] = '{0, 0, 16'h0000, 4'h0, 4'h0, 0, 3'd0, 1, 0, 4'h0,  1, 0, 16'h0000, 3'd0, 4'h0, 16'd0};

    idleInputs();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d in_ready", i), 32'(inReady), 32'(vecs[i].expReady));
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("v%0d wb_valid", i), 32'(wbValid), 32'(vecs[i].expWbValid));
      checkOutput($sformatf("v%0d wb_data", i), 32'(wbData), 32'(vecs[i].expData));
      checkOutput($sformatf("v%0d wb_addr", i), 32'(wbAddr), 32'(vecs[i].expAddr));
      checkOutput($sformatf("v%0d flags", i), 32'(flags), 32'(vecs[i].expFlags));
      checkOutput($sformatf("v%0d carry_out", i), 32'(carryOut), 32'(vecs[i].expFlags[1]));
      checkOutput($sformatf("v%0d ops_retired", i), 32'(opsRetired), 32'(vecs[i].expOps));
    end

    // Counter saturation: the 3-bit copy must stick at 7 while the 16-bit one keeps counting.
    idleInputs();
    inValid = 1'b1;
    wbReady = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("sat ops16 n=%0d", n), 32'(opsRetired), 32'(n));
      checkOutput($sformatf("sat ops3 n=%0d", n), 32'(satOps), (n > 7) ? 32'd7 : 32'(n));
    end
    checkOutput("sat in_ready", 32'(satReady), 32'd1);
    checkOutput("sat wb_valid", 32'(satWbValid), 32'd0);
    checkOutput("sat wb_data", 32'(satWbData), 32'd0);
    checkOutput("sat wb_addr", 32'(satWbAddr), 32'd0);
    checkOutput("sat flags", 32'(satFlags), 32'd0);
    checkOutput("sat carry", 32'(satCarry), 32'd0);

    // Enqueue-to-writeback latency, then head must hold under backpressure.
    idleInputs();
    inValid  = 1'b1;
    inWe     = 1'b1;
    inResult = 16'hA5A5;
    inRd     = 3'd6;
    @(posedge clk_i);
    #1;
    idleInputs();
    lat = 1;
    while (!wbValid && lat < 5) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    checkOutput("latency acc->wb_valid", 32'(lat), 32'd1);
    repeat (2) begin
      @(posedge clk_i);
      #1;
      checkOutput("hold wb_valid", 32'(wbValid), 32'd1);
      checkOutput("hold wb_data", 32'(wbData), 32'hA5A5);
      checkOutput("hold wb_addr", 32'(wbAddr), 32'd6);
    end
    wbReady = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("drain wb_valid", 32'(wbValid), 32'd0);
    checkOutput("drain wb_data", 32'(wbData), 32'd0);
    checkOutput("drain ops", 32'(opsRetired), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
